// File: rtl/note_gate_ctrl_if.sv
// Event and gate signal bundle between the MIDI decoder, the note-priority
// controller and the envelope/oscillator path of one voice.
interface note_gate_ctrl_if #(
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          evt_valid;
  logic          evt_ready;
  logic          evt_on;
  logic [6:0]    evt_note;
  logic [6:0]    evt_vel;
  logic          all_off;
  logic          gate_on;
  logic          gate_off;
  logic          gate_active;
  logic [6:0]    note_out;
  logic [6:0]    vel_out;
  logic [CW-1:0] note_count;

  // Event source side (MIDI decoder / testbench)
  modport master (
    output evt_valid, evt_on, evt_note, evt_vel, all_off,
    input  evt_ready, gate_on, gate_off, gate_active, note_out, vel_out, note_count
  );

  // Controller side
  modport slave (
    input  evt_valid, evt_on, evt_note, evt_vel, all_off,
    output evt_ready, gate_on, gate_off, gate_active, note_out, vel_out, note_count
  );
endinterface

// File: rtl/note_gate_ctrl.sv
// Monophonic last-note-priority controller. Keeps a stack of held notes
// (entry 0 = most recent), searches it one entry per cycle for each event,
// rewrites it in one cycle and then publishes gate pulses, the top note and
// its velocity together. all_off aborts any in-flight event and clears the
// stack count.
module note_gate_ctrl #(
  parameter int DEPTH  = 8,
  parameter bit LEGATO = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  note_gate_ctrl_if.slave bus
);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            IW      = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [IW-1:0] IDX_MAX = IW'(DEPTH - 1);

  // PUBLISH registers the outputs from the freshly rewritten stack so that the
  // pulses, note, velocity and count all change on the same edge.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_UPDATE  = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Stack entries are {note, velocity}
  logic [13:0]   r_stk     [DEPTH];
  logic [13:0]   w_stk_nxt [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // Latched event and search result
  logic          r_on;
  logic [6:0]    r_note;
  logic [6:0]    r_vel;
  logic [IW-1:0] r_idx;
  logic          r_found;
  logic [IW-1:0] r_k;

  logic          r_pend_on;
  logic          r_pend_off;
  logic          w_pend_on;
  logic          w_pend_off;
  logic          r_panic_off;

  logic          r_gate_on;
  logic          r_gate_off;
  logic          r_gate_active;
  logic [6:0]    r_note_out;
  logic [6:0]    r_vel_out;
  logic [CW-1:0] r_note_count;

  logic          w_ready;
  logic          w_accept;
  logic          w_hit;
  logic          w_last;

  assign w_ready  = (r_state == S_IDLE) && !bus.all_off;
  assign w_accept = bus.evt_valid && w_ready;
  // Entries at or above the count are stale and must never match
  assign w_hit    = (CW'(r_idx) < r_cnt) && (r_stk[r_idx][13:7] == r_note);
  assign w_last   = (r_idx == IDX_MAX);

  assign bus.evt_ready   = w_ready;
  assign bus.gate_on     = r_gate_on;
  assign bus.gate_off    = r_gate_off;
  assign bus.gate_active = r_gate_active;
  assign bus.note_out    = r_note_out;
  assign bus.vel_out     = r_vel_out;
  assign bus.note_count  = r_note_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; all_off returns to IDLE from anywhere
  always_comb begin
    w_state_nxt = r_state;
    if (bus.all_off) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_nxt = S_SEARCH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_SEARCH: begin
          if (w_last) begin
            w_state_nxt = S_UPDATE;
          end else begin
            w_state_nxt = S_SEARCH;
          end
        end
        S_UPDATE:  w_state_nxt = S_PUBLISH;
        S_PUBLISH: w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Latch the accepted event and walk the stack one entry per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on    <= 1'b0;
      r_note  <= 7'd0;
      r_vel   <= 7'd0;
      r_idx   <= '0;
      r_found <= 1'b0;
      r_k     <= '0;
    end else if (bus.all_off) begin
      r_idx   <= '0;
      r_found <= 1'b0;
    end else if (w_accept) begin
      // A note-on with velocity 0 is a note-off
      r_on    <= bus.evt_on && (bus.evt_vel != 7'd0);
      r_note  <= bus.evt_note;
      r_vel   <= bus.evt_vel;
      r_idx   <= '0;
      r_found <= 1'b0;
      r_k     <= '0;
    end else if (r_state == S_SEARCH) begin
      if (!r_found && w_hit) begin
        r_found <= 1'b1;
        r_k     <= r_idx;
      end else begin
        r_found <= r_found;
      end
      if (!w_last) begin
        r_idx <= r_idx + IW'(1);
      end else begin
        r_idx <= r_idx;
      end
    end else begin
      r_idx <= r_idx;
    end
  end

  // New stack contents, count and pending pulses for the latched event
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_stk_nxt[i] = r_stk[i];
    end
    w_cnt_nxt  = r_cnt;
    w_pend_on  = 1'b0;
    w_pend_off = 1'b0;
    if (r_on) begin
      // Move the note to the top; when absent everything slides down and
      // the oldest entry falls off a full stack
      w_stk_nxt[0] = {r_note, r_vel};
      for (int i = 1; i < DEPTH; i++) begin
        if (!r_found || (i <= int'(r_k))) begin
          w_stk_nxt[i] = r_stk[i-1];
        end else begin
          w_stk_nxt[i] = r_stk[i];
        end
      end
      if (!r_found && (r_cnt != CNT_MAX)) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end else begin
        w_cnt_nxt = r_cnt;
      end
      if (LEGATO) begin
        w_pend_on = (r_cnt == CW'(0));
      end else begin
        w_pend_on = 1'b1;
      end
    end else if (r_found) begin
      // Close the gap left by the released note
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(r_k)) begin
          w_stk_nxt[i] = r_stk[i+1];
        end else begin
          w_stk_nxt[i] = r_stk[i];
        end
      end
      w_stk_nxt[DEPTH-1] = 14'd0;
      w_cnt_nxt  = r_cnt - CW'(1);
      w_pend_off = (r_cnt == CW'(1));
      // Releasing the top note exposes an older one, which retriggers
      w_pend_on  = !LEGATO && (r_k == IW'(0)) && (r_cnt > CW'(1));
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Commit the stack rewrite; all_off empties the stack by clearing its count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stk[i] <= 14'd0;
      end
      r_cnt      <= '0;
      r_pend_on  <= 1'b0;
      r_pend_off <= 1'b0;
    end else if (bus.all_off) begin
      r_cnt      <= '0;
      r_pend_on  <= 1'b0;
      r_pend_off <= 1'b0;
    end else if (r_state == S_UPDATE) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stk[i] <= w_stk_nxt[i];
      end
      r_cnt      <= w_cnt_nxt;
      r_pend_on  <= w_pend_on;
      r_pend_off <= w_pend_off;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Registered outputs: pulses default low, note/velocity hold after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_on     <= 1'b0;
      r_gate_off    <= 1'b0;
      r_gate_active <= 1'b0;
      r_note_out    <= 7'd0;
      r_vel_out     <= 7'd0;
      r_note_count  <= '0;
      r_panic_off   <= 1'b0;
    end else if (bus.all_off) begin
      // Release pulse follows one edge after the clear, only if notes were held
      r_panic_off   <= (r_note_count != CW'(0));
      r_gate_on     <= 1'b0;
      r_gate_off    <= r_panic_off;
      r_gate_active <= 1'b0;
      r_note_count  <= '0;
    end else if (r_state == S_PUBLISH) begin
      r_panic_off   <= 1'b0;
      r_gate_on     <= r_pend_on;
      r_gate_off    <= r_pend_off;
      r_gate_active <= (r_cnt != CW'(0));
      r_note_count  <= r_cnt;
      if (r_cnt != CW'(0)) begin
        r_note_out <= r_stk[0][13:7];
        r_vel_out  <= r_stk[0][6:0];
      end else begin
        r_note_out <= r_note_out;
        r_vel_out  <= r_vel_out;
      end
    end else begin
      r_panic_off <= 1'b0;
      r_gate_on   <= 1'b0;
      r_gate_off  <= r_panic_off;
    end
  end

endmodule

// File: tb/tb_note_gate_ctrl.sv
// Bench for note_gate_ctrl: two DUTs (LEGATO=0 and LEGATO=1, DEPTH=4) get
// identical stimulus and are compared against a queue-based note-priority model.
module tb_note_gate_ctrl;
  localparam int DEPTH = 4;
  localparam int LAT   = DEPTH + 2;

  logic clk;
  logic rst_n;

  note_gate_ctrl_if #(.DEPTH(DEPTH)) if0 ();
  note_gate_ctrl_if #(.DEPTH(DEPTH)) if1 ();

  note_gate_ctrl #(.DEPTH(DEPTH), .LEGATO(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  note_gate_ctrl #(.DEPTH(DEPTH), .LEGATO(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: held notes, front = most recent
  logic [13:0] held[$];
  logic [6:0]  m_note = 7'd0;
  logic [6:0]  m_vel  = 7'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic on, input logic [6:0] note,
                       input logic [6:0] vel, input logic aoff);
    if0.evt_valid = v;    if1.evt_valid = v;
    if0.evt_on    = on;   if1.evt_on    = on;
    if0.evt_note  = note; if1.evt_note  = note;
    if0.evt_vel   = vel;  if1.evt_vel   = vel;
    if0.all_off   = aoff; if1.all_off   = aoff;
  endtask

  task automatic model_evt(input logic on, input logic [6:0] note, input logic [6:0] vel,
                           output logic eon0, output logic eon1, output logic eoff);
    int k;
    int prev;
    k    = -1;
    prev = held.size();
    for (int i = 0; i < held.size(); i++) begin
      if (k < 0 && held[i][13:7] == note) k = i;
    end
    eon0 = 1'b0; eon1 = 1'b0; eoff = 1'b0;
    if (on && vel != 7'd0) begin
      if (k >= 0) held.delete(k);
      held.push_front({note, vel});
      if (held.size() > DEPTH) void'(held.pop_back());
      eon0 = 1'b1;
      eon1 = (prev == 0);
    end else if (k >= 0) begin
      held.delete(k);
      eoff = (held.size() == 0);
      eon0 = (k == 0) && (held.size() > 0);
    end
    if (held.size() > 0) begin
      m_note = held[0][13:7];
      m_vel  = held[0][6:0];
    end
  endtask

  task automatic check_all(input string tag, input logic eon0, input logic eon1, input logic eoff);
    check_eq({tag, ".gon0"},  32'(if0.gate_on),    32'(eon0));
    check_eq({tag, ".gon1"},  32'(if1.gate_on),    32'(eon1));
    check_eq({tag, ".goff0"}, 32'(if0.gate_off),   32'(eoff));
    check_eq({tag, ".goff1"}, 32'(if1.gate_off),   32'(eoff));
    check_eq({tag, ".note"},  32'(if0.note_out),   32'(m_note));
    check_eq({tag, ".vel"},   32'(if0.vel_out),    32'(m_vel));
    check_eq({tag, ".note1"}, 32'(if1.note_out),   32'(m_note));
    check_eq({tag, ".cnt"},   32'(if0.note_count), held.size());
    check_eq({tag, ".cnt1"},  32'(if1.note_count), held.size());
    check_eq({tag, ".act"},   32'(if0.gate_active), 32'(held.size() != 0));
    check_eq({tag, ".rdy"},   32'({if0.evt_ready, if1.evt_ready}), 32'd3);
  endtask

  // Send one event from IDLE; abort_s >= 0 raises all_off after edge T+abort_s
  task automatic send_evt(input string tag, input logic on, input logic [6:0] note,
                          input logic [6:0] vel, input int abort_s);
    logic eon0, eon1, eoff;
    int   prev;
    @(negedge clk);
    check_eq({tag, ".idle_rdy"}, 32'({if0.evt_ready, if1.evt_ready}), 32'd3);
    drive(1'b1, on, note, vel, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    if (abort_s < 0) begin
      model_evt(on, note, vel, eon0, eon1, eoff);
      for (int j = 1; j < LAT; j++) begin
        @(posedge clk); #1;
        check_eq({tag, ".busy"}, 32'({if0.evt_ready, if0.gate_on, if0.gate_off,
                                      if1.evt_ready, if1.gate_on, if1.gate_off}), 32'd0);
      end
      @(posedge clk); #1;
      check_all(tag, eon0, eon1, eoff);
      @(posedge clk); #1;
      check_eq({tag, ".pulse_end"}, 32'({if0.gate_on, if0.gate_off, if1.gate_on, if1.gate_off}), 32'd0);
    end else begin
      for (int j = 1; j <= abort_s; j++) begin
        @(posedge clk); #1;
      end
      drive(1'b0, 1'b0, 7'd0, 7'd0, 1'b1);
      @(posedge clk); #1;
      prev = held.size();
      held.delete();
      check_eq({tag, ".ab_cnt"}, 32'({if0.note_count, if1.note_count}), 32'd0);
      check_eq({tag, ".ab_act"}, 32'({if0.gate_active, if1.gate_active}), 32'd0);
      check_eq({tag, ".ab_rdy_lo"}, 32'({if0.evt_ready, if1.evt_ready}), 32'd0);
      drive(1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
      #1;
      check_eq({tag, ".ab_rdy"}, 32'({if0.evt_ready, if1.evt_ready}), 32'd3);
      @(posedge clk); #1;
      check_eq({tag, ".ab_goff"}, 32'({if0.gate_off, if1.gate_off}), (prev != 0) ? 32'd3 : 32'd0);
      check_eq({tag, ".ab_gon"},  32'({if0.gate_on, if1.gate_on}), 32'd0);
      check_eq({tag, ".ab_note"}, 32'(if0.note_out), 32'(m_note));
      @(posedge clk); #1;
      check_eq({tag, ".ab_goff_end"}, 32'({if0.gate_off, if1.gate_off}), 32'd0);
    end
  endtask

  // all_off while idle, with a competing event that must be refused
  task automatic panic_idle(input string tag);
    int prev;
    @(negedge clk);
    drive(1'b1, 1'b1, 7'd50, 7'd77, 1'b1);
    #1;
    check_eq({tag, ".rdy_lo"}, 32'({if0.evt_ready, if1.evt_ready}), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    prev = held.size();
    held.delete();
    check_eq({tag, ".cnt"}, 32'({if0.note_count, if1.note_count}), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, ".goff"}, 32'({if0.gate_off, if1.gate_off}), (prev != 0) ? 32'd3 : 32'd0);
    for (int j = 0; j < LAT + 1; j++) begin
      @(posedge clk); #1;
      check_eq({tag, ".quiet"}, 32'({if0.gate_on, if1.gate_on, if0.evt_ready, if1.evt_ready,
                                     if0.note_count, if1.note_count}), 32'b001100_0000);
    end
  endtask

  initial begin
    logic [6:0] nt;
    logic [6:0] vl;
    int         r;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.outs", 32'({if0.gate_on, if0.gate_off, if0.gate_active, if0.note_out,
                              if0.vel_out, if0.note_count}), 32'd0);
    check_eq("rst.rdy", 32'({if0.evt_ready, if1.evt_ready}), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;

    // Single note from empty
    send_evt("t1", 1'b1, 7'd60, 7'd100, -1);
    // Retrigger vs legato
    panic_idle("p2");
    send_evt("t2a", 1'b1, 7'd60, 7'd90, -1);
    send_evt("t2b", 1'b1, 7'd64, 7'd80, -1);
    send_evt("t2c", 1'b0, 7'd64, 7'd0, -1);
    // Saturation and full release
    panic_idle("p4");
    for (int i = 0; i < 5; i++) send_evt("t4on", 1'b1, 7'(60 + i), 7'(20 + i), -1);
    for (int i = 0; i < 4; i++) send_evt("t4off", 1'b0, 7'(64 - i), 7'd5, -1);
    // Releases of absent notes
    panic_idle("p5");
    send_evt("t5a", 1'b0, 7'd70, 7'd10, -1);
    send_evt("t5b", 1'b1, 7'd60, 7'd0, -1);
    // Panic mid-search
    send_evt("t6a", 1'b1, 7'd60, 7'd40, -1);
    send_evt("t6b", 1'b1, 7'd62, 7'd41, -1);
    send_evt("t6ab", 1'b1, 7'd65, 7'd50, 2);
    send_evt("t6c", 1'b0, 7'd65, 7'd50, -1);
    send_evt("t6d", 1'b1, 7'd66, 7'd51, -1);

    // Randomized traffic over a narrow note range to force hits
    for (int n = 0; n < 150; n++) begin
      r  = int'($urandom_range(0, 29));
      nt = 7'(60 + $urandom_range(0, 5));
      vl = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      if (r == 0) begin
        panic_idle("rp");
      end else if (r == 1) begin
        send_evt("rab", 1'b1, nt, vl, int'($urandom_range(0, DEPTH - 1)));
      end else begin
        send_evt("rnd", ($urandom_range(0, 9) < 6), nt, vl, -1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
